fifo_ctrl: RTL
==============

# fifo_ctrl

Pointer and flag controller for the transaction-layer FIFOs. It drives the write and read ports of the 8-entry × 10-bit dual-port memory, so the memory itself stays a passive array. The controller accepts push/pop requests from the upstream and downstream logic and generates the memory enables and pointers. It also keeps the occupancy count, the full/empty and programmable almost-full/almost-empty flags, a read-valid strobe aligned with the memory's registered `data_out`, and a sticky error flag.

## Interface
- `DATA_W`, 10, data width of the attached memory (not used internally; kept for instantiation consistency)
- `ADDR_W`, 3, pointer width; DEPTH = 2**ADDR_W = 8
- `clk`  in  1  single clock, all state updates on rising edge
- `reset_L`  in  1  synchronous, active-low reset
- `push`  in  1  write request; data presented by upstream directly on memory `data_in` in the same cycle
- `pop`  in  1  read request
- `af_th`  in  ADDR_W+1  almost-full threshold, legal 1..DEPTH
- `ae_th`  in  ADDR_W+1  almost-empty threshold, legal 0..DEPTH-1
- `wr_en`  out  1  memory write enable
- `wr_ptr`  out  ADDR_W  memory write address
- `rd_en`  out  1  memory read enable
- `rd_ptr`  out  ADDR_W  memory read address
- `valid_out`  out  1  memory `data_out` carries popped word this cycle
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `full`, `empty`  out  1 each  occupancy flags
- `almost_full`, `almost_empty`  out  1 each  threshold flags
- `error`  out  1  sticky overflow/underflow indicator

## Operation
- Accept conditions:
  - push_ok = `push` & ~`full` & `reset_L`
  - pop_ok = `pop` & ~`empty` & `reset_L`
- Accept conditions are evaluated on the registered flags from the current cycle.
- `wr_en` = push_ok and `rd_en` = pop_ok. Both are combinational and forced 0 while `reset_L`=0.
- `wr_ptr` and `rd_ptr` are registers presented directly to the memory.
- Pointer update at the edge:
  - on push_ok, `wr_ptr` += 1
  - on pop_ok, `rd_ptr` += 1
  - both pointers wrap modulo DEPTH (7 → 0); there is no extra wrap bit, occupancy comes from `count`.
- Count update at the edge:
  - push_ok only: +1
  - pop_ok only: −1
  - both or neither: unchanged
- Simultaneous push+pop:
  - Not full and not empty: both accepted, count holds, both pointers advance.
  - Full: pop accepted; push rejected and flagged as error, even though a slot frees this cycle.
  - Empty: push accepted; pop rejected and flagged as error.
- Flags are combinational from registered `count`:
  - `full` = (count == DEPTH)
  - `empty` = (count == 0)
  - `almost_full` = (count ≥ af_th)
  - `almost_empty` = (count ≤ ae_th)
- Thresholds are sampled continuously. A threshold change is reflected in the flags in the same cycle.
- `error` is set at the edge on (`push` & `full`) or (`pop` & `empty`) while `reset_L`=1. It is cleared only by reset.
- Reset (`reset_L`=0 at an edge) puts the block in this state: `wr_ptr`=0, `rd_ptr`=0, `count`=0, `valid_out`=0, `error`=0. Resulting outputs:
  - `empty`=1, `full`=0
  - `almost_empty`=1
  - `almost_full`=0 for legal `af_th`
- Reset mid-operation discards all content. Any in-flight `valid_out` is cleared at the reset edge.

## Timing
- Write: push_ok in cycle N → memory captures `data_in` at `wr_ptr` on edge N. `wr_ptr` and `count` show new values in N+1.
- Read: pop_ok in cycle N → memory registers word at `rd_ptr` on edge N. `valid_out`=1 during N+1, aligned with memory `data_out`.
- Read latency is 1 cycle. Back-to-back pops give a continuous `valid_out` stream.
- Flags lag the accepted operation by exactly one cycle: a push into count=7 makes `full`=1 in the next cycle.
- Throughput: one push and one pop per cycle.
- There is no combinational path from `push`/`pop` to any flag; they reach only `wr_en`/`rd_en`.

## Test plan
- Reset then 8 pushes (0x0FF, 0x011, …, 0x077) → `wr_ptr` 0→1…→0 (wrap), `count` ends at 8, `full`=1 in the cycle after the 8th push, `almost_full`=1 once count ≥ `af_th`=6.
- From full, 8 pops → `rd_en` for 8 cycles, `valid_out`=1 in cycles 2–9, data 0x0FF…0x077 in order, `empty`=1 after the last pop, `error`=0.
- Streaming at count=4 with push+pop every cycle for 10 cycles → `count` stays 4 and both pointers advance 10 (mod 8 = 2).
- Push while full → `wr_en`=0, `count` stays 8, `error`=1 next cycle and remains 1.
- Push+pop while empty → push accepted, pop rejected, `count`=1, `error`=1, `valid_out`=0.
- With count=5, pull `reset_L` low for one cycle → next cycle `count`=0, pointers 0, `empty`=1, `error`=0, `valid_out`=0. `wr_en`/`rd_en` stay 0 during reset even with push/pop held high.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for an 8-entry dual-port FIFO memory.
// The memory is a passive array; this block owns the write/read enables and
// addresses, the occupancy count, the full/empty/almost flags, a read-valid
// strobe aligned with the memory's registered data_out, and a sticky error flag.
//
// Ports:
//   clk           single clock, rising edge
//   reset_L       synchronous active-low reset
//   push, pop     write / read requests
//   af_th, ae_th  almost-full (1..DEPTH) and almost-empty (0..DEPTH-1) thresholds
//   wr_en, wr_ptr memory write enable and address
//   rd_en, rd_ptr memory read enable and address
//   valid_out     memory data_out holds a popped word this cycle
//   count         occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty  occupancy flags
//   error         sticky overflow/underflow, cleared only by reset
module fifo_ctrl #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W:0]   af_th,
    input  logic [ADDR_W:0]   ae_th,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              valid_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              error
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);

    // The data path lives in the attached memory; DATA_W only has to be sane.
    if (DATA_W == 0) begin : g_bad_data_w
        $error("fifo_ctrl: DATA_W must be nonzero");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic              push_ok, pop_ok;

    // Flags depend only on registered count and the thresholds, never on push/pop.
    always_comb begin
        full         = (count_q == DepthCnt);
        empty        = (count_q == '0);
        almost_full  = (count_q >= af_th);
        almost_empty = (count_q <= ae_th);
    end

    // Accept decisions use this cycle's registered flags, so a push into a full
    // FIFO is rejected even if a simultaneous pop frees a slot.
    always_comb begin
        push_ok = push & ~full & reset_L;
        pop_ok  = pop & ~empty & reset_L;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        // Memory registers the read word on the pop edge, so valid trails by one.
        valid_d = pop_ok;
        error_d = error_q | (push & full) | (pop & empty);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        wr_en     = push_ok;
        rd_en     = pop_ok;
        wr_ptr    = wr_ptr_q;
        rd_ptr    = rd_ptr_q;
        count     = count_q;
        valid_out = valid_q;
        error     = error_q;
    end

endmodule
